// File: rtl/cnn_layer_accel_weight_seq_ctrl.sv
// Weight-sequence table sequencer: walks NUM_SEQ addresses once per kernel
// for N kernels, with stall hold and read-aligned valid/last/kernel strobes.
module cnn_layer_accel_weight_seq_ctrl #(
  parameter int NUM_SEQ = 5,
  parameter int ADDR_W  = 3,
  parameter int KRNL_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [KRNL_W-1:0] cfg_num_kernels,
  input  logic              stall,
  output logic [ADDR_W-1:0] seq_rdAddr,
  output logic              seq_rden,
  output logic              seq_valid,
  output logic              seq_last,
  output logic [KRNL_W-1:0] seq_krnl_idx,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SEQ - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [KRNL_W-1:0] krnl_q, krnl_d;
  logic [KRNL_W-1:0] n_q, n_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic [KRNL_W-1:0] kidx_q, kidx_d;
  logic              rden;
  logic              at_last;
  logic              last_krnl;

  assign rden      = (state_q == RUN) && !stall;
  assign at_last   = (addr_q == LAST_ADDR);
  // Compare against N-1 so N = 2^KRNL_W-1 never needs a wider counter
  assign last_krnl = (krnl_q == (n_q - KRNL_W'(1)));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    krnl_d  = krnl_q;
    n_d     = n_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          n_d    = cfg_num_kernels;
          addr_d = '0;
          krnl_d = '0;
          if (cfg_num_kernels == '0) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (rden) begin
          if (at_last) begin
            addr_d = '0;
            if (last_krnl) begin
              state_d = DRAIN;
            end else begin
              krnl_d = krnl_q + KRNL_W'(1);
            end
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end
      DRAIN: state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d = rden;
    last_d  = rden && at_last;
    kidx_d  = rden ? krnl_q : kidx_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      krnl_q  <= '0;
      n_q     <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      kidx_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      krnl_q  <= krnl_d;
      n_q     <= n_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      kidx_q  <= kidx_d;
    end
  end

  assign seq_rdAddr   = addr_q;
  assign seq_rden     = rden;
  assign seq_valid    = valid_q;
  assign seq_last     = last_q;
  assign seq_krnl_idx = kidx_q;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);

endmodule

// File: tb/tb_cnn_layer_accel_weight_seq_ctrl.sv
// Directed bench for the weight-sequence sequencer with a read scoreboard.
module tb_cnn_layer_accel_weight_seq_ctrl;

  localparam int NUM_SEQ = 5;
  localparam int ADDR_W  = 3;
  localparam int KRNL_W  = 10;

  typedef struct {
    int addr;
    int last;
    int kidx;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [KRNL_W-1:0] cfg_num_kernels = '0;
  logic              stall = 1'b0;
  logic [ADDR_W-1:0] seq_rdAddr;
  logic              seq_rden;
  logic              seq_valid;
  logic              seq_last;
  logic [KRNL_W-1:0] seq_krnl_idx;
  logic              busy;
  logic              done;

  cnn_layer_accel_weight_seq_ctrl #(
    .NUM_SEQ(NUM_SEQ),
    .ADDR_W (ADDR_W),
    .KRNL_W (KRNL_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .cfg_num_kernels(cfg_num_kernels),
    .stall          (stall),
    .seq_rdAddr     (seq_rdAddr),
    .seq_rden       (seq_rden),
    .seq_valid      (seq_valid),
    .seq_last       (seq_last),
    .seq_krnl_idx   (seq_krnl_idx),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   base = 0;
  int   errors = 0;
  int   checks = 0;
  int   n_rd, n_val, n_done, n_busy, done_cyc, last_rd;
  int   last_cycs[$];
  exp_t exp_q[$];
  exp_t pend_q[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (seq_rden) begin
        n_rd++;
        last_rd = cyc - base;
        if (exp_q.size() == 0) begin
          chk("extra_read", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rd_addr", int'(seq_rdAddr), e.addr);
          pend_q.push_back(e);
        end
      end
      if (seq_valid) begin
        n_val++;
        if (seq_last) last_cycs.push_back(cyc - base);
        if (pend_q.size() == 0) begin
          chk("extra_valid", 1, 0);
        end else begin
          exp_t e;
          e = pend_q.pop_front();
          chk("valid_last", int'(seq_last), e.last);
          chk("valid_kidx", int'(seq_krnl_idx), e.kidx);
        end
      end
      if (busy) n_busy++;
      if (done) begin
        n_done++;
        done_cyc = cyc - base;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_run(input int n);
    n_rd = 0; n_val = 0; n_done = 0; n_busy = 0;
    done_cyc = -1; last_rd = -1;
    last_cycs.delete();
    for (int k = 0; k < n; k++)
      for (int a = 0; a < NUM_SEQ; a++)
        exp_q.push_back('{a, (a == NUM_SEQ - 1) ? 1 : 0, k});
    start = 1'b1;
    cfg_num_kernels = KRNL_W'(n);
    base = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int k;
    k = 0;
    while (n_done == 0 && k < lim) begin
      step();
      k++;
    end
    chk("done_seen", n_done, 1);
    @(negedge clk);
    chk("idle_after_done", int'(busy), 0);
    chk("sb_empty", exp_q.size() + pend_q.size(), 0);
    step();
  endtask

  task automatic to_rel(input int c);
    while (cyc - base < c) step();
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_addr", int'(seq_rdAddr), 0);
    chk("rst_outs", int'({seq_rden, seq_valid, seq_last, busy, done}), 0);
    chk("rst_kidx", int'(seq_krnl_idx), 0);
    step();

    // basic run
    begin_run(2);
    wait_done(40);
    chk("basic_done_cyc", done_cyc, 12);
    chk("basic_reads", n_rd, 10);
    chk("basic_valids", n_val, 10);
    chk("basic_busy_cycles", n_busy, 12);
    chk("basic_last_rd", last_rd, 10);
    chk("basic_nlast", last_cycs.size(), 2);
    if (last_cycs.size() == 2) begin
      chk("basic_last0", last_cycs[0], 6);
      chk("basic_last1", last_cycs[1], 11);
    end

    // stall in cycles 3-4
    begin_run(2);
    to_rel(3);
    stall = 1'b1;
    @(negedge clk);
    chk("stall_rden3", int'(seq_rden), 0);
    chk("stall_addr3", int'(seq_rdAddr), 2);
    step();
    @(negedge clk);
    chk("stall_rden4", int'(seq_rden), 0);
    chk("stall_addr4", int'(seq_rdAddr), 2);
    chk("stall_valid4", int'(seq_valid), 0);
    step();
    stall = 1'b0;
    @(negedge clk);
    chk("stall_valid5", int'(seq_valid), 0);
    wait_done(40);
    chk("stall_done_cyc", done_cyc, 14);
    chk("stall_last_rd", last_rd, 12);
    chk("stall_valids", n_val, 10);

    // zero kernels
    begin_run(0);
    @(negedge clk);
    chk("zero_busy1", int'(busy), 1);
    chk("zero_done1", int'(done), 1);
    wait_done(10);
    chk("zero_done_cyc", done_cyc, 1);
    chk("zero_reads", n_rd, 0);

    // start while busy is ignored
    begin_run(2);
    to_rel(5);
    start = 1'b1;
    cfg_num_kernels = KRNL_W'(7);
    step();
    start = 1'b0;
    wait_done(60);
    chk("sib_done_cyc", done_cyc, 12);
    chk("sib_reads", n_rd, 10);

    // reset mid-run
    begin_run(2);
    to_rel(6);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    pend_q.delete();
    @(negedge clk);
    chk("mrst_outs", int'({seq_rden, seq_valid, seq_last, busy, done}), 0);
    chk("mrst_addr", int'(seq_rdAddr), 0);
    chk("mrst_kidx", int'(seq_krnl_idx), 0);
    chk("mrst_no_done", n_done, 0);
    step();
    begin_run(1);
    wait_done(30);
    chk("mrst_done_cyc", done_cyc, 7);
    chk("mrst_reads", n_rd, 5);

    // stall on the final read
    begin_run(2);
    to_rel(10);
    stall = 1'b1;
    step();
    stall = 1'b0;
    wait_done(40);
    chk("fstall_done_cyc", done_cyc, 13);
    chk("fstall_last_rd", last_rd, 11);
    chk("fstall_nlast", last_cycs.size(), 2);
    if (last_cycs.size() == 2) chk("fstall_last1", last_cycs[1], 12);

    // maximum kernel count
    begin_run(1023);
    wait_done(6000);
    chk("max_reads", n_rd, 1023 * NUM_SEQ);
    chk("max_done_cyc", done_cyc, 1023 * NUM_SEQ + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cnn_layer_accel_weight_seq_ctrl.md
Name: cnn_layer_accel_weight_seq_ctrl

Overview:
- Sequencer for the weight-sequence data table.
- Once started, it walks the table's read address through all NUM_SEQ entries, once per kernel, for a configured kernel count.
- Handles downstream stalls and emits valid, last and kernel-index strobes aligned with the table's 1-cycle read data.
- Sits between the layer control FSM (start/done) and the weight-sequence table feeding the weight-select datapath.

Parameters:
- NUM_SEQ, 5, entries per weight sequence (table depth); must be >= 2.
- ADDR_W, 3, table address width, clog2(NUM_SEQ).
- KRNL_W, 10, width of kernel count and kernel index.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle start pulse; sampled only in IDLE.
- cfg_num_kernels  in  KRNL_W  kernels to sequence; sampled on the accepted start.
- stall  in  1  downstream hold; suppresses reads while high.
- seq_rdAddr  out  ADDR_W  table read address (registered).
- seq_rden  out  1  table read enable; combinational: state==RUN && !stall.
- seq_valid  out  1  table dout valid; seq_rden delayed 1 cycle.
- seq_last  out  1  with seq_valid: this entry is index NUM_SEQ-1 of a kernel.
- seq_krnl_idx  out  KRNL_W  kernel index of the entry currently valid.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at end of run.

Behaviour:
- Reset values: state IDLE; seq_rdAddr 0; internal kernel counter 0; seq_valid, seq_last, done, busy all 0; seq_krnl_idx 0.
- Reset mid-run aborts immediately. No done is emitted, and the next cycle is IDLE with all outputs at reset values.
- States:
  - IDLE: start && cfg_num_kernels!=0 → RUN. Latch N, seq_rdAddr=0, krnl counter=0.
  - IDLE: start && cfg_num_kernels==0 → DONE. No reads are issued.
  - RUN: each cycle with !stall, one read is issued at seq_rdAddr.
  - RUN address step: if seq_rdAddr==NUM_SEQ-1, wrap to 0 and increment the krnl counter; else increment seq_rdAddr.
  - RUN exit: a read issued at addr NUM_SEQ-1 with krnl counter==N-1 → DRAIN.
  - RUN with stall: seq_rden=0, address and counter hold, state holds.
  - DRAIN: no read; the last data becomes valid this cycle → DONE.
  - DONE: done=1 for one cycle → IDLE.
- Latency: table read data is valid 1 cycle after seq_rden. seq_valid, seq_last and seq_krnl_idx are registers loaded from the issuing cycle's rden, (addr==NUM_SEQ-1) and krnl counter.
- Read count: exactly N*NUM_SEQ reads per run, in order 0..NUM_SEQ-1, repeated N times.
- start while busy: ignored, and cfg_num_kernels is not resampled.
- stall in DRAIN/DONE/IDLE: no effect.
- Stall on the final-read cycle: the read is not issued, the state stays RUN, and it exits only when the read is actually issued.
- Kernel counter compares against the latched N; N=2^KRNL_W-1 must complete without overflow.

Test Plan:
- Basic run: NUM_SEQ=5, start at cycle 0, N=2, no stall → seq_rden cycles 1-10 with addr 0,1,2,3,4,0,1,2,3,4. seq_valid cycles 2-11. seq_last at cycles 6 and 11. seq_krnl_idx 0 for cycles 2-6, 1 for cycles 7-11. done at cycle 12. busy cycles 1-12.
- Stall: as above plus stall high in cycles 3-4 → rden low cycles 3-4, addr held at 2. seq_valid low cycles 4-5. Last read at cycle 12, done at cycle 14, total 10 valids.
- Zero kernels: start with N=0 → no rden ever. busy=1 and done=1 at cycle 1, IDLE at cycle 2.
- Start while busy: second start with N=7 at cycle 5 of the basic run → ignored; still exactly 10 reads, done at cycle 12.
- Reset mid-run: rst at cycle 6 of the basic run → cycle 7 is IDLE, all outputs 0, no done. A new start with N=1 then gives 5 reads and done 7 cycles after the start.
- Stall on final read: basic run with stall at cycle 10 → final addr-4 read issued at cycle 11, seq_last at cycle 12, done at cycle 13.
